// File: rtl/rv32_mod_fetch_align.sv
// Fetch/align stage: single-outstanding word fetch into a 3-halfword buffer, emits 16/32-bit instrs with PC.
// Zero-wait memory gives instr one cycle after the request; instr_ready low holds outputs and stops fetching at >=2 halfwords.
module rv32_mod_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [47:0] buf_q, buf_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        skip_low_q, skip_low_d;

    logic        head_is32;
    logic        consume;
    logic [1:0]  consume_hw;
    logic [1:0]  count_ac;
    logic [47:0] buf_ac;
    logic        req_issue;
    logic        req_active;
    logic        append;
    logic        append_two;
    logic [15:0] app_lo;

    assign head_is32   = (buf_q[1:0] == 2'b11);
    assign instr_valid = (count_q >= 2'd2) || ((count_q == 2'd1) && !head_is32);
    assign instr       = !instr_valid ? 32'h0 :
                         head_is32    ? buf_q[31:0] : {16'h0, buf_q[15:0]};
    assign instr_compressed = instr_valid && !head_is32;
    assign instr_pc    = head_pc_q;

    // A redirect cycle ignores any downstream handshake.
    assign consume    = instr_valid && instr_ready && !redirect_valid;
    assign consume_hw = !consume ? 2'd0 : (head_is32 ? 2'd2 : 2'd1);
    assign count_ac   = count_q - consume_hw;
    assign buf_ac     = (consume_hw == 2'd2) ? {32'h0, buf_q[47:32]} :
                        (consume_hw == 2'd1) ? {16'h0, buf_q[47:16]} : buf_q;

    assign req_issue  = (state_q == IDLE) && (count_ac <= 2'd1);
    assign req_active = req_issue || (state_q == WAIT) || (state_q == DISCARD);
    assign fetch_req  = req_active && !rst;
    // Once a request is out its address must not move, even if a redirect retargets the next fetch.
    assign fetch_addr = (state_q == IDLE) ? fetch_addr_q : pend_addr_q;

    assign append     = fetch_req && fetch_ack && !redirect_valid && (state_q != DISCARD);
    assign append_two = !skip_low_q;
    assign app_lo     = skip_low_q ? fetch_data[31:16] : fetch_data[15:0];

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_ac;
        count_d      = count_ac;
        head_pc_d    = head_pc_q;
        fetch_addr_d = fetch_addr_q;
        pend_addr_d  = pend_addr_q;
        skip_low_d   = skip_low_q;

        if (consume) begin
            head_pc_d = head_pc_q + (head_is32 ? 32'd4 : 32'd2);
        end
        if (req_issue) begin
            pend_addr_d = fetch_addr_q;
        end

        if (redirect_valid) begin
            count_d      = 2'd0;
            head_pc_d    = redirect_pc & 32'hFFFF_FFFE;
            fetch_addr_d = redirect_pc & 32'hFFFF_FFFC;
            skip_low_d   = redirect_pc[1];
            state_d      = (req_active && !fetch_ack) ? DISCARD : IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req_issue && !fetch_ack) state_d = WAIT;
                WAIT:    if (fetch_ack) state_d = IDLE;
                DISCARD: if (fetch_ack) state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (append) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                skip_low_d   = 1'b0;
                count_d      = count_ac + (append_two ? 2'd2 : 2'd1);
                case (count_ac)
                    2'd0: begin
                        buf_d[15:0] = app_lo;
                        if (append_two) buf_d[31:16] = fetch_data[31:16];
                    end
                    2'd1: begin
                        buf_d[31:16] = app_lo;
                        if (append_two) buf_d[47:32] = fetch_data[31:16];
                    end
                    default: buf_d[47:32] = app_lo;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            buf_q        <= '0;
            count_q      <= 2'd0;
            head_pc_q    <= {RESET_PC[31:1], 1'b0};
            fetch_addr_q <= {RESET_PC[31:2], 2'b00};
            pend_addr_q  <= {RESET_PC[31:2], 2'b00};
            skip_low_q   <= RESET_PC[1];
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            count_q      <= count_d;
            head_pc_q    <= head_pc_d;
            fetch_addr_q <= fetch_addr_d;
            pend_addr_q  <= pend_addr_d;
            skip_low_q   <= skip_low_d;
        end
    end

endmodule

// File: tb/tb_rv32_mod_fetch_align.sv
// Directed bench for rv32_mod_fetch_align with a word memory whose ack delay is adjustable.
module tb_rv32_mod_fetch_align;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    int ack_delay = 0;
    int wait_cnt  = 0;

    rv32_mod_fetch_align #(.RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .fetch_ack        (fetch_ack),
        .fetch_data       (fetch_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory acks after ack_delay cycles of a held request (0 = same cycle).
    always_comb begin
        fetch_ack  = fetch_req && (wait_cnt >= ack_delay);
        fetch_data = mem[fetch_addr[9:2]];
    end

    always_ff @(posedge clk) begin
        if (fetch_req && !fetch_ack) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the next instruction, checks it, then lets it be consumed.
    task automatic expect_instr(input string tag, input logic [31:0] e_instr,
                                input logic [31:0] e_pc, input logic e_c);
        int n;
        n = 0;
        while (!instr_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, {31'b0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, e_instr);
        chk({tag, "_pc"}, instr_pc, e_pc);
        chk({tag, "_c"}, {31'b0, instr_compressed}, {31'b0, e_c});
        tick();
    endtask

    initial begin
        int n;
        logic stale;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0001_0001;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b0;

        // Reset state and first-fetch latency
        mem[0] = 32'h00A0_0093;
        tick();
        tick();
        chk("rst_vld", {31'b0, instr_valid}, 32'd0);
        chk("rst_req", {31'b0, fetch_req}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        rst = 1'b0;
        #1;
        chk("t1_req", {31'b0, fetch_req}, 32'd1);
        chk("t1_addr", fetch_addr, 32'h0);
        tick();
        chk("t1_vld", {31'b0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'h00A0_0093);
        chk("t1_pc", instr_pc, 32'h0);
        chk("t1_c", {31'b0, instr_compressed}, 32'd0);
        chk("t1_req_full", {31'b0, fetch_req}, 32'd0);

        // Two compressed instructions in one word
        rst    = 1'b1;
        mem[0] = 32'h4501_4081;
        tick();
        rst         = 1'b0;
        instr_ready = 1'b1;
        expect_instr("t2a", 32'h0000_4081, 32'h0, 1'b1);
        expect_instr("t2b", 32'h0000_4501, 32'h2, 1'b1);

        // 32-bit instruction straddling a word boundary, slow memory
        rst       = 1'b1;
        mem[0]    = 32'h0093_4505;
        mem[1]    = 32'h4081_00A0;
        ack_delay = 2;
        tick();
        rst = 1'b0;
        expect_instr("t3a", 32'h0000_4505, 32'h0, 1'b1);
        chk("t3_wait_vld", {31'b0, instr_valid}, 32'd0);
        chk("t3_wait_instr", instr, 32'h0);
        expect_instr("t3b", 32'h00A0_0093, 32'h2, 1'b0);
        expect_instr("t3c", 32'h0000_4081, 32'h6, 1'b1);

        // Redirect to an odd-halfword target
        ack_delay      = 0;
        mem[65]        = 32'h4505_FFFF;
        mem[66]        = 32'h0001_0001;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0106;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t4_vld", {31'b0, instr_valid}, 32'd0);
        chk("t4_req", {31'b0, fetch_req}, 32'd1);
        chk("t4_addr", fetch_addr, 32'h0000_0104);
        expect_instr("t4a", 32'h0000_4505, 32'h0000_0106, 1'b1);
        expect_instr("t4b", 32'h0000_0001, 32'h0000_0108, 1'b1);

        // Redirect while a slow fetch is outstanding
        ack_delay      = 3;
        mem[64]        = 32'h0005_0005;
        mem[128]       = 32'h4081_4505;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        #1;
        n = 0;
        while (!(fetch_req && fetch_addr == 32'h0000_0100) && n < 20) begin
            tick();
            n++;
        end
        chk("t5_req100", {31'b0, fetch_req}, 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t5_hold_req", {31'b0, fetch_req}, 32'd1);
        chk("t5_hold_addr", fetch_addr, 32'h0000_0100);
        chk("t5_vld", {31'b0, instr_valid}, 32'd0);
        stale = 1'b0;
        n = 0;
        while (!(fetch_req && fetch_addr == 32'h0000_0200) && n < 20) begin
            if (instr_valid) stale = 1'b1;
            tick();
            n++;
        end
        chk("t5_stale", {31'b0, stale}, 32'd0);
        chk("t5_addr200", fetch_addr, 32'h0000_0200);
        expect_instr("t5a", 32'h0000_4505, 32'h0000_0200, 1'b1);
        expect_instr("t5b", 32'h0000_4081, 32'h0000_0202, 1'b1);

        // Backpressure on a compressed stream
        ack_delay      = 0;
        mem[192]       = 32'h2105_2005;
        mem[193]       = 32'h2305_2205;
        mem[194]       = 32'h2505_2405;
        instr_ready    = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("t6_vld0", {31'b0, instr_valid}, 32'd0);
        chk("t6_addr", fetch_addr, 32'h0000_0300);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_instr", instr, 32'h0000_2005);
            chk("t6_hold_pc", instr_pc, 32'h0000_0300);
            chk("t6_hold_req", {31'b0, fetch_req}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        expect_instr("t6a", 32'h0000_2005, 32'h0000_0300, 1'b1);
        expect_instr("t6b", 32'h0000_2105, 32'h0000_0302, 1'b1);
        expect_instr("t6c", 32'h0000_2205, 32'h0000_0304, 1'b1);
        expect_instr("t6d", 32'h0000_2305, 32'h0000_0306, 1'b1);
        expect_instr("t6e", 32'h0000_2405, 32'h0000_0308, 1'b1);
        expect_instr("t6f", 32'h0000_2505, 32'h0000_030A, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
